// File: rtl/fir_seq_pkg.sv
// Shared types and default widths for the 2-channel FIR sequencer.
// The sequencer FSM state enum lives here so checkers can decode dbg_state_o.
package fir_seq_pkg;

  localparam int IN_W_DEF    = 16;
  localparam int AUX_W_DEF   = 24;
  localparam int SINK_W_DEF  = 18;
  localparam int SRC_W_DEF   = 24;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEND_L = 3'd2,
    SEND_R = 3'd3,
    WAIT   = 3'd4
  } state_t;

  // Counter width able to hold the value t.
  function automatic int cnt_width(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/fir_2ch_sequencer_if.sv
// Link between the sequencer and the shared FIR: sink beats out, source beats back.
// Neither direction has a ready: a beat is transferred on every cycle its valid is high.
interface fir_2ch_sequencer_if #(
  parameter int SINK_W = 18,
  parameter int SRC_W  = 24
);
  logic [SINK_W-1:0] sink_data_o;
  logic              sink_valid_o;
  logic              sink_sop_o;
  logic              sink_eop_o;
  logic [SRC_W-1:0]  src_data_i;
  logic              src_valid_i;
  logic              src_sop_i;
  logic              src_eop_i;

  modport master (
    output sink_data_o, sink_valid_o, sink_sop_o, sink_eop_o,
    input  src_data_i, src_valid_i, src_sop_i, src_eop_i
  );

  modport slave (
    input  sink_data_o, sink_valid_o, sink_sop_o, sink_eop_o,
    output src_data_i, src_valid_i, src_sop_i, src_eop_i
  );
endinterface

// File: rtl/fir_seq_capture.sv
// Demultiplexes FIR source beats into left/right registers and raises
// valid_o the cycle after the eop beat; beats are only taken while wait_i is high.
module fir_seq_capture #(
  parameter int SRC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wait_i,
  input  logic [SRC_W-1:0] src_data_i,
  input  logic             src_valid_i,
  input  logic             src_sop_i,
  input  logic             src_eop_i,
  output logic [SRC_W-1:0] left_o,
  output logic [SRC_W-1:0] right_o,
  output logic             valid_o
);

  logic [SRC_W-1:0] left_q, left_d;
  logic [SRC_W-1:0] right_q, right_d;
  logic             valid_q, valid_d;

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = 1'b0;
    if (wait_i && src_valid_i) begin
      if (src_sop_i) begin
        left_d = src_data_i;
      end else begin
        right_d = src_data_i;
      end
      valid_d = src_eop_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
    end
  end

  assign left_o  = left_q;
  assign right_o = right_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fir_2ch_sequencer.sv
// Frames stereo pairs into L(sop)/R(eop) bursts for the shared FIR and collects the result.
// Optional aux mono mix is enabled by defining AUX_MIX_EN.
module fir_2ch_sequencer
  import fir_seq_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int AUX_W   = AUX_W_DEF,
  parameter int SINK_W  = SINK_W_DEF,
  parameter int SRC_W   = SRC_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               AMCLK_i,
  input  logic               nARST,
  input  logic [IN_W-1:0]    in_left_i,
  input  logic [IN_W-1:0]    in_right_i,
  input  logic               in_valid_i,
  input  logic [AUX_W-1:0]   aux_data_i,
  input  logic               aux_valid_i,
  fir_2ch_sequencer_if.master fir,
  output logic [SRC_W-1:0]   out_left_o,
  output logic [SRC_W-1:0]   out_right_o,
  output logic               out_valid_o,
  output logic               busy_o,
  output logic [7:0]         overrun_cnt_o,
  output logic               timeout_o,
  output state_t             dbg_state_o
);

  localparam int WD_W = cnt_width(TIMEOUT);

  state_t            state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [IN_W-1:0]   hold_l_q, hold_l_d;
  logic [IN_W-1:0]   hold_r_q, hold_r_d;
  logic [SINK_W-1:0] mix_l_q, mix_l_d;
  logic [SINK_W-1:0] mix_r_q, mix_r_d;
  logic [7:0]        ovr_q, ovr_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic [SINK_W-1:0] aux_term;
  logic [SINK_W-1:0] mix_l, mix_r;
  logic [SINK_W-1:0] sink_data;
  logic              sink_valid, sink_sop, sink_eop;
  logic              timeout;

`ifdef AUX_MIX_EN
  logic [AUX_W-1:0] aux_q, aux_d;

  always_comb begin
    aux_d = aux_q;
    if (aux_valid_i) aux_d = aux_data_i;
  end

  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) aux_q <= '0;
    else        aux_q <= aux_d;
  end

  // Top SINK_W-1 aux bits, sign-extended by one to line up with the sink width.
  assign aux_term = {aux_q[AUX_W-1], aux_q[AUX_W-1 -: SINK_W-1]};
`else
  logic aux_unused;
  assign aux_unused = ^{aux_data_i, aux_valid_i};
  assign aux_term   = '0;
`endif

  assign mix_l = {{(SINK_W-IN_W){hold_l_q[IN_W-1]}}, hold_l_q} + aux_term;
  assign mix_r = {{(SINK_W-IN_W){hold_r_q[IN_W-1]}}, hold_r_q} + aux_term;

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    mix_l_d     = mix_l_q;
    mix_r_d     = mix_r_q;
    ovr_d       = ovr_q;
    wd_d        = wd_q;
    sink_valid  = 1'b0;
    sink_sop    = 1'b0;
    sink_eop    = 1'b0;
    sink_data   = '0;
    timeout     = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) state_d = LOAD;
      end
      LOAD: begin
        mix_l_d     = mix_l;
        mix_r_d     = mix_r;
        hold_full_d = 1'b0;
        state_d     = SEND_L;
      end
      SEND_L: begin
        sink_valid = 1'b1;
        sink_sop   = 1'b1;
        sink_data  = mix_l_q;
        state_d    = SEND_R;
      end
      SEND_R: begin
        sink_valid = 1'b1;
        sink_eop   = 1'b1;
        sink_data  = mix_r_q;
        wd_d       = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (fir.src_valid_i && fir.src_eop_i) begin
          state_d = IDLE;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Evaluated after the FSM so a strobe coinciding with LOAD refills the buffer.
    if (in_valid_i) begin
      if (hold_full_q && (state_q != LOAD) && (ovr_q != 8'hFF)) begin
        ovr_d = ovr_q + 8'd1;
      end
      hold_full_d = 1'b1;
      hold_l_d    = in_left_i;
      hold_r_d    = in_right_i;
    end
  end

  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      mix_l_q     <= '0;
      mix_r_q     <= '0;
      ovr_q       <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      mix_l_q     <= mix_l_d;
      mix_r_q     <= mix_r_d;
      ovr_q       <= ovr_d;
      wd_q        <= wd_d;
    end
  end

  fir_seq_capture #(
    .SRC_W (SRC_W)
  ) u_capture (
    .clk         (AMCLK_i),
    .rst_n       (nARST),
    .wait_i      (state_q == WAIT),
    .src_data_i  (fir.src_data_i),
    .src_valid_i (fir.src_valid_i),
    .src_sop_i   (fir.src_sop_i),
    .src_eop_i   (fir.src_eop_i),
    .left_o      (out_left_o),
    .right_o     (out_right_o),
    .valid_o     (out_valid_o)
  );

  assign fir.sink_data_o  = sink_data;
  assign fir.sink_valid_o = sink_valid;
  assign fir.sink_sop_o   = sink_sop;
  assign fir.sink_eop_o   = sink_eop;

  assign busy_o        = (state_q != IDLE);
  assign overrun_cnt_o = ovr_q;
  assign timeout_o     = timeout;
  assign dbg_state_o   = state_q;

endmodule
